// File: rtl/mem_wb_stage_if.sv
// Signal bundle for the memory/write-back stage: the execute-side bundle,
// the data-RAM req/ack port, the register-file write port and error pulses.
// "slave" is the stage's own view; "master" is the surrounding pipeline,
// memory and register file seen from the other side.
interface mem_wb_stage_if #(
  parameter int ADDR_W = 10
);
  // Execute bundle: valid/ready. A bundle transfers on a rising edge where
  // ex_valid and ex_ready are both 1; execute holds the bundle while ex_ready
  // is 0. Memory port: req/ack. mem_req stays 1 with addr/data/strobe/we
  // stable until a rising edge samples mem_ack=1 (or the wait bound expires);
  // mem_ack is ignored whenever mem_req is 0.
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_load;
  logic              ex_store;
  logic [2:0]        ex_funct3;
  logic [4:0]        ex_rd;
  logic [31:0]       ex_result;
  logic [31:0]       ex_store_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  logic              misalign_err;
  logic              bus_err;

  modport slave (
    input  ex_valid, ex_load, ex_store, ex_funct3, ex_rd, ex_result,
           ex_store_data, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           rf_we, rf_waddr, rf_wdata, misalign_err, bus_err
  );

  modport master (
    output ex_valid, ex_load, ex_store, ex_funct3, ex_rd, ex_result,
           ex_store_data, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           rf_we, rf_waddr, rf_wdata, misalign_err, bus_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Pipeline stage 4: executes loads/stores against the data RAM and writes
// ALU and load results back to the register file. One memory access may be
// outstanding; execute is stalled (ex_ready=0) for its whole duration.
module mem_wb_stage #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            Reset,
  mem_wb_stage_if.slave   bus,
  output logic            dbg_state   // 1 while a memory access is outstanding
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MEM  = 1'b1
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] wait_cnt;

  // Fields of the outstanding access needed when it completes.
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic             load_q;

  logic             accept;
  logic             is_mem;
  logic             misaligned;
  logic             acked;
  logic             timed_out;
  logic [1:0]       off;
  logic [3:0]       strb_nx;
  logic [31:0]      wdata_nx;
  logic [31:0]      shifted;
  logic [31:0]      load_val;

  // Address bits above the RAM window are not decoded.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^bus.ex_result[31:ADDR_W+2];

  assign off       = bus.ex_result[1:0];
  assign is_mem    = bus.ex_load | bus.ex_store;
  assign dbg_state = (state == S_MEM);

  // Stage can take a bundle only when no access is outstanding and not in reset.
  always_comb begin
    bus.ex_ready = (state == S_IDLE) && !Reset;
    accept       = bus.ex_valid && bus.ex_ready;
  end

  // Alignment rule by access size; unlisted size encodings behave as word.
  always_comb begin
    misaligned = 1'b0;
    case (bus.ex_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  end

  // Store lane placement: strobes follow the byte offset, data is replicated
  // across lanes so the RAM can take whichever lanes are enabled.
  always_comb begin
    strb_nx  = 4'b1111;
    wdata_nx = bus.ex_store_data;
    case (bus.ex_funct3[1:0])
      2'b00: begin
        strb_nx  = 4'b0001 << off;
        wdata_nx = {4{bus.ex_store_data[7:0]}};
      end
      2'b01: begin
        strb_nx  = 4'b0011 << off;
        wdata_nx = {2{bus.ex_store_data[15:0]}};
      end
      default: begin
        strb_nx  = 4'b1111;
        wdata_nx = bus.ex_store_data;
      end
    endcase
  end

  // Load lane select and sign/zero extension (funct3[2] = unsigned).
  always_comb begin
    shifted  = bus.mem_rdata >> {off_q, 3'b000};
    load_val = shifted;
    case (f3_q[1:0])
      2'b00:   load_val = f3_q[2] ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = f3_q[2] ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Completion events for the outstanding access; ack on the last allowed
  // cycle wins over the timeout.
  always_comb begin
    acked     = (state == S_MEM) && bus.mem_req && bus.mem_ack;
    timed_out = (state == S_MEM) && !bus.mem_ack &&
                (wait_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Next-state logic: enter MEM on an aligned load/store, leave on ack/timeout.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept && is_mem && !misaligned) state_nx = S_MEM;
      S_MEM:  if (acked || timed_out)              state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Wait counter: zero outside MEM, counts MEM cycles that saw no ack.
  always_ff @(posedge clk) begin
    if (Reset || state == S_IDLE) wait_cnt <= '0;
    else if (!acked)              wait_cnt <= wait_cnt + 1'b1;
  end

  // Memory port, register-file port and error pulses.
  always_ff @(posedge clk) begin
    if (Reset) begin
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.mem_wstrb    <= '0;
      bus.rf_we        <= 1'b0;
      bus.rf_waddr     <= '0;
      bus.rf_wdata     <= '0;
      bus.misalign_err <= 1'b0;
      bus.bus_err      <= 1'b0;
      off_q            <= '0;
      f3_q             <= '0;
      rd_q             <= '0;
      load_q           <= 1'b0;
    end else begin
      bus.rf_we        <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.bus_err      <= 1'b0;

      if (accept) begin
        if (!is_mem) begin
          if (bus.ex_rd != 5'd0) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= bus.ex_rd;
            bus.rf_wdata <= bus.ex_result;
          end
        end else if (misaligned) begin
          bus.misalign_err <= 1'b1;
        end else begin
          bus.mem_req   <= 1'b1;
          bus.mem_we    <= bus.ex_store;
          bus.mem_addr  <= bus.ex_result[ADDR_W+1:2];
          bus.mem_wstrb <= bus.ex_store ? strb_nx : 4'b0000;
          if (bus.ex_store) bus.mem_wdata <= wdata_nx;
          off_q  <= off;
          f3_q   <= bus.ex_funct3;
          rd_q   <= bus.ex_rd;
          load_q <= bus.ex_load;
        end
      end

      if (acked) begin
        bus.mem_req <= 1'b0;
        if (load_q && rd_q != 5'd0) begin
          bus.rf_we    <= 1'b1;
          bus.rf_waddr <= rd_q;
          bus.rf_wdata <= load_val;
        end
      end else if (timed_out) begin
        bus.mem_req <= 1'b0;
        bus.bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage. Expected memory-port and
// write-back values come from a byte-level model of the access rules.
module tb_mem_wb_stage;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic dbg_state;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.ADDR_W(ADDR_W)) bus ();

  mem_wb_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input int off);
    logic [3:0] s = '0;
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + size_of(f3)) s[k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = sd[8*(k % size_of(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] rdata);
    logic [31:0] v = '0;
    int sz = size_of(f3);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_bundle(input bit ld, input bit st, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [31:0] res,
                              input logic [31:0] sd);
    bus.ex_valid      = 1'b1;
    bus.ex_load       = ld;
    bus.ex_store      = st;
    bus.ex_funct3     = f3;
    bus.ex_rd         = rd;
    bus.ex_result     = res;
    bus.ex_store_data = sd;
  endtask

  // Scrambles the bundle fields after acceptance so held outputs are proven stable.
  task automatic drop_bundle();
    bus.ex_valid      = 1'b0;
    bus.ex_load       = 1'($urandom);
    bus.ex_store      = ~bus.ex_load;
    bus.ex_funct3     = 3'($urandom);
    bus.ex_rd         = 5'($urandom);
    bus.ex_result     = $urandom;
    bus.ex_store_data = $urandom;
  endtask

  task automatic check_rf(input logic [4:0] rd);
    chk("rf_waddr", bus.rf_waddr, rd);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed=rf_write expected=no_pending_entry");
    end else begin
      chk("rf_wdata", bus.rf_wdata, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_load = 1'b0; bus.ex_store = 1'b0;
    bus.ex_funct3 = '0; bus.ex_rd = '0; bus.ex_result = '0; bus.ex_store_data = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    chk("rst_ex_ready", bus.ex_ready, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_rf_waddr", bus.rf_waddr, 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    chk("rst_misalign", bus.misalign_err, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    Reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.ex_ready, 1);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] res);
    drive_bundle(1'b0, 1'b0, 3'($urandom), rd, res, $urandom);
    chk("alu_ready", bus.ex_ready, 1);
    if (rd != 5'd0) exp_q.push_back(res);
    tick();
    drop_bundle();
    chk("alu_rf_we", bus.rf_we, (rd != 5'd0));
    chk("alu_mem_req", bus.mem_req, 0);
    chk("alu_misalign", bus.misalign_err, 0);
    if (rd != 5'd0) check_rf(rd);
  endtask

  // ack_at: req cycle (1-based) in which mem_ack is raised; 0 = never.
  task automatic mem_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int ack_at);
    int off = int'(addr[1:0]);
    bit done = 1'b0;
    logic [ADDR_W-1:0] exp_addr = addr[ADDR_W+1:2];
    logic [3:0] exp_strb = ld ? 4'b0000 : model_strb(f3, off);
    logic [31:0] exp_wdata = model_wdata(f3, sd);
    drive_bundle(ld, !ld, f3, rd, addr, sd);
    chk("mem_accept_ready", bus.ex_ready, 1);
    tick();
    drop_bundle();
    if (model_misaligned(f3, addr)) begin
      chk("mis_err", bus.misalign_err, 1);
      chk("mis_mem_req", bus.mem_req, 0);
      chk("mis_rf_we", bus.rf_we, 0);
      chk("mis_ready", bus.ex_ready, 1);
      tick();
      chk("mis_err_pulse", bus.misalign_err, 0);
      chk("mis_mem_req2", bus.mem_req, 0);
      return;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      chk("req_high", bus.mem_req, 1);
      chk("req_ready_low", bus.ex_ready, 0);
      chk("req_addr", bus.mem_addr, exp_addr);
      chk("req_we", bus.mem_we, !ld);
      chk("req_wstrb", bus.mem_wstrb, exp_strb);
      if (!ld) chk("req_wdata", bus.mem_wdata, exp_wdata);
      chk("req_rf_we", bus.rf_we, 0);
      bus.mem_ack   = (k == ack_at);
      bus.mem_rdata = (k == ack_at) ? rdata : $urandom;
      tick();
      bus.mem_ack = 1'b0;
      if (k == ack_at) begin
        done = 1'b1;
        break;
      end
    end
    chk("end_req_low", bus.mem_req, 0);
    chk("end_ready", bus.ex_ready, 1);
    if (done) begin
      chk("ack_bus_err", bus.bus_err, 0);
      chk("ack_rf_we", bus.rf_we, (ld && rd != 5'd0));
      if (ld && rd != 5'd0) begin
        exp_q.push_back(model_load(f3, off, rdata));
        check_rf(rd);
      end
    end else begin
      chk("to_bus_err", bus.bus_err, 1);
      chk("to_rf_we", bus.rf_we, 0);
      tick();
      chk("to_bus_err_pulse", bus.bus_err, 0);
      chk("to_req_low", bus.mem_req, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] f3_tab[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    do_reset();

    // Back-to-back ALU results, one to x0.
    alu_op(5'd5, 32'h0000_1234);
    alu_op(5'd0, 32'h0000_FFFF);
    chk("alu_ready_kept", bus.ex_ready, 1);

    // SB to byte 3 of word 0x100.
    mem_op(1'b0, 3'b000, 32'h0000_0403, 32'h0000_00AB, 5'd7, 32'h0, 2);
    chk("sb_lane_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    chk("sb_lane_strb", bus.mem_wstrb, 4'b1000);

    // Sub-word loads with a 3-cycle ack.
    mem_op(1'b1, 3'b000, 32'h2, 32'h0, 5'd9,  32'h0080_0000, 3);
    chk("lb_value", bus.rf_wdata, 32'hFFFF_FF80);
    mem_op(1'b1, 3'b100, 32'h2, 32'h0, 5'd10, 32'h0080_0000, 3);
    chk("lbu_value", bus.rf_wdata, 32'h0000_0080);
    mem_op(1'b1, 3'b001, 32'h2, 32'h0, 5'd11, 32'h8001_0000, 3);
    chk("lh_value", bus.rf_wdata, 32'hFFFF_8001);

    // Misaligned LW and SH.
    mem_op(1'b1, 3'b010, 32'h6, 32'h0, 5'd12, 32'h0, 1);
    mem_op(1'b0, 3'b001, 32'h5, 32'h1234_5678, 5'd13, 32'h0, 1);

    // Timeout, then ack on the last allowed cycle.
    mem_op(1'b1, 3'b010, 32'h10, 32'h0, 5'd3, 32'hDEAD_BEEF, 0);
    mem_op(1'b1, 3'b010, 32'h10, 32'h0, 5'd3, 32'hCAFE_F00D, TIMEOUT);

    // Zero-wait load followed directly by an ALU op; load to x0 still hits memory.
    mem_op(1'b1, 3'b010, 32'h44, 32'h0, 5'd14, 32'h0BAD_C0DE, 1);
    alu_op(5'd15, 32'h5555_AAAA);
    mem_op(1'b1, 3'b101, 32'h46, 32'h0, 5'd0, 32'hFFFF_0000, 1);

    // Reset in the 2nd wait cycle of a load; a late ack must be ignored.
    drive_bundle(1'b1, 1'b0, 3'b010, 5'd4, 32'h20, 32'h0);
    tick();
    drop_bundle();
    chk("rstmem_req1", bus.mem_req, 1);
    tick();
    chk("rstmem_req2", bus.mem_req, 1);
    Reset = 1'b1;
    tick();
    chk("rstmem_req_low", bus.mem_req, 0);
    chk("rstmem_wstrb", bus.mem_wstrb, 0);
    chk("rstmem_addr", bus.mem_addr, 0);
    chk("rstmem_rf_we", bus.rf_we, 0);
    chk("rstmem_bus_err", bus.bus_err, 0);
    Reset = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = $urandom;
    #1;
    chk("rstmem_ready", bus.ex_ready, 1);
    tick();
    bus.mem_ack = 1'b0;
    chk("late_ack_rf_we", bus.rf_we, 0);
    chk("late_ack_req", bus.mem_req, 0);
    chk("late_ack_bus_err", bus.bus_err, 0);

    // Randomized mix of ALU ops, loads and stores.
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      logic [4:0] rd = 5'($urandom_range(0, 31));
      int ack = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5);
      case (kind)
        0: alu_op(rd, $urandom);
        1: mem_op(1'b1, f3_tab[$urandom_range(0, 4)], $urandom, 32'h0, rd, $urandom, ack);
        default: mem_op(1'b0, 3'($urandom_range(0, 2)), $urandom, $urandom, rd, 32'h0, ack);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
